// File: rtl/encoder8x3_pkg.sv
// Shared widths and pure helper functions for the registered 8-to-3 priority encoder.
package encoder8x3_pkg;

    localparam int ENC_IN_W  = 8;
    localparam int ENC_OUT_W = $clog2(ENC_IN_W);

    // Operates on a 32-bit view so any request width up to 32 can reuse it.
    function automatic int highest_set_idx(input logic [31:0] v);
        int idx;
        idx = 0;
        for (int i = 0; i < 32; i++) begin
            if (v[i]) begin
                idx = i;
            end
        end
        return idx;
    endfunction

    function automatic logic more_than_one(input logic [31:0] v);
        return (v & (v - 32'd1)) != 32'd0;
    endfunction

endpackage

// File: rtl/encoder8x3_core.sv
// Combinational priority core: highest set bit index, any-bit flag and multi-bit flag.
module encoder8x3_core
    import encoder8x3_pkg::*;
#(
    parameter int IN_W  = ENC_IN_W,
    parameter int OUT_W = $clog2(IN_W)
) (
    input  logic [IN_W-1:0]  din,
    output logic [OUT_W-1:0] idx,
    output logic             any,
    output logic             multi_c
);

    logic [31:0] din_wide;

    always_comb begin
        din_wide = 32'(din);
        idx      = OUT_W'(highest_set_idx(din_wide));
        any      = |din;
        multi_c  = more_than_one(din_wide);
    end

endmodule

// File: rtl/encoder8x3.sv
// Registered 8-to-3 priority encoder; en low or an empty request vector drives outputs idle.
module encoder8x3
    import encoder8x3_pkg::*;
#(
    parameter int IN_W  = ENC_IN_W,
    parameter int OUT_W = $clog2(IN_W)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [IN_W-1:0]  din,
    output logic [OUT_W-1:0] dout,
    output logic             valid,
    output logic             multi
);

    logic [OUT_W-1:0] idx;
    logic             any;
    logic             multi_c;

    logic [OUT_W-1:0] dout_d, dout_q;
    logic             valid_d, valid_q;
    logic             multi_d, multi_q;

    encoder8x3_core #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) u_core (
        .din     (din),
        .idx     (idx),
        .any     (any),
        .multi_c (multi_c)
    );

    // Idle is all-zero; valid is what distinguishes a bit-0 encode from idle.
    always_comb begin
        dout_d  = '0;
        valid_d = 1'b0;
        multi_d = 1'b0;
        if (en && any) begin
            dout_d  = idx;
            valid_d = 1'b1;
            multi_d = multi_c;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_q  <= '0;
            valid_q <= 1'b0;
            multi_q <= 1'b0;
        end else begin
            dout_q  <= dout_d;
            valid_q <= valid_d;
            multi_q <= multi_d;
        end
    end

    assign dout  = dout_q;
    assign valid = valid_q;
    assign multi = multi_q;

endmodule

// File: tb/tb_encoder8x3.sv
// Scoreboard bench for encoder8x3: expectations queued at drive time, compared one edge later.
module tb_encoder8x3;

    typedef struct {
        logic [2:0] dout;
        logic       valid;
        logic       multi;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [7:0] din;
    logic [2:0] dout;
    logic       valid;
    logic       multi;

    exp_t expQ[$];
    exp_t monItem;
    int   checks = 0;
    int   fails  = 0;

    encoder8x3 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .din   (din),
        .dout  (dout),
        .valid (valid),
        .multi (multi)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic e, input logic [7:0] d,
                                 input logic [2:0] xDout, input logic xValid, input logic xMulti);
        exp_t item;
        @(negedge clk);
        en  = e;
        din = d;
        item.dout  = xDout;
        item.valid = xValid;
        item.multi = xMulti;
        expQ.push_back(item);
    endtask

    // Independent reference: scan from the top bit down, count set bits.
    task automatic applyModeled(input logic e, input logic [7:0] d);
        logic [2:0] xi;
        logic       found;
        xi    = 3'd0;
        found = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            if (d[i] && !found) begin
                xi    = 3'(i);
                found = 1'b1;
            end
        end
        if (e && found) applyStimulus(e, d, xi, 1'b1, $countones(d) > 1);
        else            applyStimulus(e, d, 3'd0, 1'b0, 1'b0);
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, "_dout"},  32'(dout),  32'd0);
        checkOutput({tag, "_valid"}, 32'(valid), 32'd0);
        checkOutput({tag, "_multi"}, 32'(multi), 32'd0);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rst_n && expQ.size() > 0) begin
                monItem = expQ.pop_front();
                checkOutput("sb_dout",  32'(dout),  32'(monItem.dout));
                checkOutput("sb_valid", 32'(valid), 32'(monItem.valid));
                checkOutput("sb_multi", 32'(multi), 32'(monItem.multi));
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        en    = 1'b1;
        din   = 8'h80;
        #1;
        checkIdle("reset_t0");
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            checkIdle("reset_hold");
        end
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) applyStimulus(1'b0, 8'(1 << i), 3'd0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, 8'(1 << i), 3'(i), 1'b1, 1'b0);

        applyStimulus(1'b1, 8'h00, 3'd0, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'h01, 3'd0, 1'b1, 1'b0);

        applyStimulus(1'b1, 8'h81, 3'd7, 1'b1, 1'b1);
        applyStimulus(1'b1, 8'h0C, 3'd3, 1'b1, 1'b1);
        applyStimulus(1'b1, 8'hFF, 3'd7, 1'b1, 1'b1);

        applyStimulus(1'b1, 8'h40, 3'd6, 1'b1, 1'b0);
        applyStimulus(1'b0, 8'h40, 3'd0, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'h40, 3'd6, 1'b1, 1'b0);

        for (int i = 0; i < 24; i++) applyModeled(($urandom_range(0, 3) != 0), 8'($urandom));

        // Mid-stream reset: outputs must clear without a clock edge.
        applyStimulus(1'b1, 8'h20, 3'd5, 1'b1, 1'b0);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checkIdle("async_reset");
        @(negedge clk);
        rst_n = 1'b1;

        applyStimulus(1'b1, 8'h10, 3'd4, 1'b1, 1'b0);
        applyStimulus(1'b1, 8'h03, 3'd1, 1'b1, 1'b1);

        for (int i = 0; i < 10 && expQ.size() > 0; i++) @(posedge clk);
        #2;
        checkOutput("sb_drain", 32'(expQ.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/encoder8x3.md
Name: encoder8x3

Overview:
- Registered 8-to-3 binary encoder with enable.
- Converts an 8-bit one-hot request vector into the 3-bit index of the asserted bit.
- Priority resolution: highest set bit wins.
- Sits between request/interrupt-style sources and downstream index consumers. Outputs are registered for timing closure.

Parameters:
- IN_W, 8, number of request inputs. Must be a power of two, at least 2.
- OUT_W, $clog2(IN_W) = 3, width of the encoded index.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- en  input  1  encode enable; when low, outputs are forced to idle on the next edge
- din  input  IN_W  request vector (nominally one-hot)
- dout  output  OUT_W  registered index of highest set din bit
- valid  output  1  registered; high when dout holds a real encode result
- multi  output  1  registered; high when more than one din bit was set in the sampled cycle

Behaviour:
- Reset: rst_n low asynchronously forces dout=0, valid=0, multi=0. Release is synchronous to clk in use; the first update is at the first rising edge after deassertion.
- Latency: one cycle. Values sampled on en/din at rising edge N appear on outputs after edge N and hold until edge N+1.
- Combinational core: idx = position of the highest-numbered set bit of din; any = |din; multi_c = (din & (din-1)) != 0.
- en=1, din nonzero: dout<=idx, valid<=1, multi<=multi_c.
- en=1, din=0: dout<=0, valid<=0, multi<=0.
- en=0: dout<=0, valid<=0, multi<=0, regardless of din.
- One-hot encoding: din=8'h01->0, 8'h02->1, 8'h04->2, 8'h08->3, 8'h10->4, 8'h20->5, 8'h40->6, 8'h80->7.
- Non-one-hot input: highest bit wins and multi=1. Example: 8'h81 -> dout=7, multi=1.
- dout=0 is ambiguous between "bit0 set" and "idle"; consumers must qualify with valid.
- Reset mid-operation: outputs clear immediately; no other state exists.
- X on din while en=1 is illegal; no X-propagation guarantees.
- No internal state beyond the three output registers.

Decomposition:
- Package encoder8x3_pkg holds:
  - IN_W and OUT_W defaults
  - a pure function for highest-set-bit index
  - a pure function for the more-than-one-bit test
- Sub-module encoder8x3_core: purely combinational. Takes din; produces idx, any, multi_c.
- Top encoder8x3 adds the en gating and the async-reset output registers.

Test Plan:
- Reset: hold rst_n=0 with en=1, din=8'h80 -> dout=0, valid=0, multi=0 throughout. Assert rst_n=0 mid-stream with dout=5 -> all outputs 0 immediately, without waiting for a clk edge.
- Enable low sweep: en=0, din=2**i for i=0..7, one value per clock -> dout=0, valid=0, multi=0 every cycle.
- Enable high sweep: en=1, din=2**i for i=0..7, one per clock -> one cycle later dout=i, valid=1, multi=0. Sequence is 0,1,2,3,4,5,6,7.
- Zero input: en=1, din=8'h00 -> next cycle dout=0, valid=0, multi=0. Then din=8'h01 -> dout=0, valid=1, distinguishing the two cases.
- Priority/multi: en=1, din=8'h81 -> dout=7, multi=1, valid=1. din=8'h0C -> dout=3, multi=1. din=8'hFF -> dout=7, multi=1.
- Enable toggle: en=1,din=8'h40 then en=0,din=8'h40 then en=1 -> outputs per cycle: dout=6,valid=1; then dout=0,valid=0; then dout=6,valid=1.
